// File: rtl/mips20_pkg.sv
// Shared definitions for the 20-bit MIPS-style pipeline.
// Holds default datapath/control widths and bit positions inside the control bundle.
package mips20_pkg;

  localparam int unsigned DATA_W_DEF  = 20;
  localparam int unsigned CTRL_W_DEF  = 10;
  localparam int unsigned ALUOP_W_DEF = 3;
  localparam int unsigned REG_AW_DEF  = 3;
  localparam int unsigned CNT_W_DEF   = 16;

  // Control bundle bit positions (bit 0 = regdest)
  localparam int unsigned CTRL_REGDEST  = 0;
  localparam int unsigned CTRL_REGWRITE = 1;
  localparam int unsigned CTRL_ALUSRC   = 2;
  localparam int unsigned CTRL_MEMREAD  = 3;
  localparam int unsigned CTRL_MEMWRITE = 4;
  localparam int unsigned CTRL_MEMTOREG = 5;
  localparam int unsigned CTRL_J        = 6;
  localparam int unsigned CTRL_BRANCH   = 7;
  localparam int unsigned CTRL_JMEM     = 8;
  localparam int unsigned CTRL_STW      = 9;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector: flags when the instruction waiting in ID reads the
// register that the load currently in EX will write.
// Ports:
//   i_out_valid  EX stage holds a real instruction
//   i_memread    EX instruction is a load
//   i_out_dst    EX destination register
//   i_in_valid   ID holds a real instruction
//   i_in_rs/rt   ID source registers
//   i_flush      stage is being squashed (no hazard reported)
//   o_hazard     load-use hazard (combinational)
module load_use_detect #(
  parameter int unsigned REG_AW = 3
) (
  input  logic              i_out_valid,
  input  logic              i_memread,
  input  logic [REG_AW-1:0] i_out_dst,
  input  logic              i_in_valid,
  input  logic [REG_AW-1:0] i_in_rs,
  input  logic [REG_AW-1:0] i_in_rt,
  input  logic              i_flush,
  output logic              o_hazard
);

  logic w_dst_nonzero;
  logic w_src_match;

  // r0 is hard-wired zero, so a load targeting it can never create a dependency
  assign w_dst_nonzero = (i_out_dst != '0);
  assign w_src_match   = (i_out_dst == i_in_rs) | (i_out_dst == i_in_rt);

  assign o_hazard = i_out_valid & i_memread & w_dst_nonzero & i_in_valid
                    & w_src_match & ~i_flush;

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with flush, downstream stall and load-use bubble
// insertion, plus a saturating count of inserted hazard bubbles.
// Ports:
//   clk, rst                 clock, async active-high reset
//   in_valid / in_ready      ID handshake (in_ready is combinational)
//   in_ctrl, in_aluop        control bundle and ALU op from ID
//   in_* datapath, in_rs/rt/dst  datapath fields and register addresses
//   flush, ex_stall, cnt_clr squash, hold, counter clear
//   out_*                    registered copies presented to EX
//   hazard                   load-use hazard (combinational)
//   hazard_cnt               number of hazard bubbles inserted (saturating)
module id_ex_pipe_reg
  import mips20_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned CTRL_W  = CTRL_W_DEF,
  parameter int unsigned ALUOP_W = ALUOP_W_DEF,
  parameter int unsigned REG_AW  = REG_AW_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CTRL_W-1:0]  in_ctrl,
  input  logic [ALUOP_W-1:0] in_aluop,
  input  logic [DATA_W-1:0]  in_shift_jump,
  input  logic [DATA_W-1:0]  in_pc_inc,
  input  logic [DATA_W-1:0]  in_rd1,
  input  logic [DATA_W-1:0]  in_rd2,
  input  logic [DATA_W-1:0]  in_sext,
  input  logic [DATA_W-1:0]  in_instr,
  input  logic [REG_AW-1:0]  in_rs,
  input  logic [REG_AW-1:0]  in_rt,
  input  logic [REG_AW-1:0]  in_dst,
  input  logic               flush,
  input  logic               ex_stall,
  input  logic               cnt_clr,
  output logic               out_valid,
  output logic [CTRL_W-1:0]  out_ctrl,
  output logic [ALUOP_W-1:0] out_aluop,
  output logic [DATA_W-1:0]  out_shift_jump,
  output logic [DATA_W-1:0]  out_pc_inc,
  output logic [DATA_W-1:0]  out_rd1,
  output logic [DATA_W-1:0]  out_rd2,
  output logic [DATA_W-1:0]  out_sext,
  output logic [DATA_W-1:0]  out_instr,
  output logic [REG_AW-1:0]  out_dst,
  output logic               hazard,
  output logic [CNT_W-1:0]   hazard_cnt
);

  logic               r_valid;
  logic [CTRL_W-1:0]  r_ctrl;
  logic [ALUOP_W-1:0] r_aluop;
  logic [DATA_W-1:0]  r_shift_jump;
  logic [DATA_W-1:0]  r_pc_inc;
  logic [DATA_W-1:0]  r_rd1;
  logic [DATA_W-1:0]  r_rd2;
  logic [DATA_W-1:0]  r_sext;
  logic [DATA_W-1:0]  r_instr;
  logic [REG_AW-1:0]  r_dst;
  logic [CNT_W-1:0]   r_hazard_cnt;

  logic w_hazard;
  logic w_load;
  logic w_bubble;
  logic w_cnt_inc;

  load_use_detect #(
    .REG_AW (REG_AW)
  ) u_detect (
    .i_out_valid (r_valid),
    .i_memread   (r_ctrl[CTRL_MEMREAD]),
    .i_out_dst   (r_dst),
    .i_in_valid  (in_valid),
    .i_in_rs     (in_rs),
    .i_in_rt     (in_rt),
    .i_flush     (flush),
    .o_hazard    (w_hazard)
  );

  // Edge priority: flush > ex_stall > hazard > load (hazard already excludes flush)
  assign w_bubble  = ~flush & ~ex_stall & (w_hazard | ~in_valid);
  assign w_load    = ~flush & ~ex_stall & ~w_hazard & in_valid;
  assign w_cnt_inc = w_hazard & ~ex_stall & (r_hazard_cnt != {CNT_W{1'b1}});

  // A flushed instruction counts as consumed, so ID may advance during flush
  assign in_ready = flush | (~ex_stall & ~w_hazard);
  assign hazard   = w_hazard;

  // Control half: cleared on flush/bubble so nothing downstream writes or branches
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      r_aluop <= '0;
    end else if (flush | w_bubble) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      r_aluop <= '0;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_ctrl  <= in_ctrl;
      r_aluop <= in_aluop;
    end
  end

  // Datapath half: only changes on a real load, holds through bubbles and stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift_jump <= '0;
      r_pc_inc     <= '0;
      r_rd1        <= '0;
      r_rd2        <= '0;
      r_sext       <= '0;
      r_instr      <= '0;
      r_dst        <= '0;
    end else if (w_load) begin
      r_shift_jump <= in_shift_jump;
      r_pc_inc     <= in_pc_inc;
      r_rd1        <= in_rd1;
      r_rd2        <= in_rd2;
      r_sext       <= in_sext;
      r_instr      <= in_instr;
      r_dst        <= in_dst;
    end
  end

  // Saturating hazard-bubble counter; clear wins over increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hazard_cnt <= '0;
    end else if (cnt_clr) begin
      r_hazard_cnt <= '0;
    end else if (w_cnt_inc) begin
      r_hazard_cnt <= r_hazard_cnt + CNT_W'(1);
    end
  end

  assign out_valid      = r_valid;
  assign out_ctrl       = r_ctrl;
  assign out_aluop      = r_aluop;
  assign out_shift_jump = r_shift_jump;
  assign out_pc_inc     = r_pc_inc;
  assign out_rd1        = r_rd1;
  assign out_rd2        = r_rd2;
  assign out_sext       = r_sext;
  assign out_instr      = r_instr;
  assign out_dst        = r_dst;
  assign hazard_cnt     = r_hazard_cnt;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed bench for id_ex_pipe_reg: default instance plus a CNT_W=2 instance
// sharing the same stimulus for the saturation scenario.
module tb_id_ex_pipe_reg;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [9:0]  in_ctrl;
  logic [2:0]  in_aluop;
  logic [19:0] in_shift_jump, in_pc_inc, in_rd1, in_rd2, in_sext, in_instr;
  logic [2:0]  in_rs, in_rt, in_dst;
  logic        flush, ex_stall, cnt_clr;

  logic        in_ready, out_valid, hazard;
  logic [9:0]  out_ctrl;
  logic [2:0]  out_aluop, out_dst;
  logic [19:0] out_shift_jump, out_pc_inc, out_rd1, out_rd2, out_sext, out_instr;
  logic [15:0] hazard_cnt;

  logic        s_in_ready, s_out_valid, s_hazard;
  logic [9:0]  s_out_ctrl;
  logic [2:0]  s_out_aluop, s_out_dst;
  logic [19:0] s_out_shift_jump, s_out_pc_inc, s_out_rd1, s_out_rd2, s_out_sext, s_out_instr;
  logic [1:0]  s_hazard_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  id_ex_pipe_reg u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_aluop(in_aluop), .in_shift_jump(in_shift_jump),
    .in_pc_inc(in_pc_inc), .in_rd1(in_rd1), .in_rd2(in_rd2), .in_sext(in_sext),
    .in_instr(in_instr), .in_rs(in_rs), .in_rt(in_rt), .in_dst(in_dst),
    .flush(flush), .ex_stall(ex_stall), .cnt_clr(cnt_clr),
    .out_valid(out_valid), .out_ctrl(out_ctrl), .out_aluop(out_aluop),
    .out_shift_jump(out_shift_jump), .out_pc_inc(out_pc_inc), .out_rd1(out_rd1),
    .out_rd2(out_rd2), .out_sext(out_sext), .out_instr(out_instr),
    .out_dst(out_dst), .hazard(hazard), .hazard_cnt(hazard_cnt)
  );

  id_ex_pipe_reg #(.CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_ctrl(in_ctrl), .in_aluop(in_aluop), .in_shift_jump(in_shift_jump),
    .in_pc_inc(in_pc_inc), .in_rd1(in_rd1), .in_rd2(in_rd2), .in_sext(in_sext),
    .in_instr(in_instr), .in_rs(in_rs), .in_rt(in_rt), .in_dst(in_dst),
    .flush(flush), .ex_stall(ex_stall), .cnt_clr(cnt_clr),
    .out_valid(s_out_valid), .out_ctrl(s_out_ctrl), .out_aluop(s_out_aluop),
    .out_shift_jump(s_out_shift_jump), .out_pc_inc(s_out_pc_inc), .out_rd1(s_out_rd1),
    .out_rd2(s_out_rd2), .out_sext(s_out_sext), .out_instr(s_out_instr),
    .out_dst(s_out_dst), .hazard(s_hazard), .hazard_cnt(s_hazard_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle; inputs are then driven away from the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Datapath fields derive from seed: shift_jump=seed, pc_inc=+1, rd1=+2, rd2=+3, sext=+4, instr=+5
  task automatic present(input logic v, input logic [9:0] c, input logic [2:0] a,
                         input logic [19:0] seed, input logic [2:0] rs,
                         input logic [2:0] rt, input logic [2:0] dst);
    in_valid      = v;
    in_ctrl       = c;
    in_aluop      = a;
    in_shift_jump = seed;
    in_pc_inc     = seed + 20'd1;
    in_rd1        = seed + 20'd2;
    in_rd2        = seed + 20'd3;
    in_sext       = seed + 20'd4;
    in_instr      = seed + 20'd5;
    in_rs         = rs;
    in_rt         = rt;
    in_dst        = dst;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; ex_stall = 1'b0; cnt_clr = 1'b0;
    present(1'b0, 10'h0, 3'd0, 20'h0, 3'd0, 3'd0, 3'd0);
    #3;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b exp 0", out_valid); end
    n_tests++; if (out_ctrl !== 10'h0) begin n_fail++; $display("FAIL reset_ctrl: got %h exp 000", out_ctrl); end
    n_tests++; if (hazard_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_cnt: got %h exp 0", hazard_cnt); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b exp 1", in_ready); end
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_load();
    present(1'b1, 10'h2A2, 3'd5, 20'h12345, 3'd1, 3'd2, 3'd4);
    #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL load_ready: got %b exp 1", in_ready); end
    n_tests++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL load_hazard: got %b exp 0", hazard); end
    tick();
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL load_valid: got %b exp 1", out_valid); end
    n_tests++; if (out_ctrl !== 10'h2A2) begin n_fail++; $display("FAIL load_ctrl: got %h exp 2a2", out_ctrl); end
    n_tests++; if (out_aluop !== 3'd5) begin n_fail++; $display("FAIL load_aluop: got %0d exp 5", out_aluop); end
    n_tests++; if (out_shift_jump !== 20'h12345) begin n_fail++; $display("FAIL load_sj: got %h exp 12345", out_shift_jump); end
    n_tests++; if (out_pc_inc !== 20'h12346) begin n_fail++; $display("FAIL load_pc: got %h exp 12346", out_pc_inc); end
    n_tests++; if (out_rd1 !== 20'h12347) begin n_fail++; $display("FAIL load_rd1: got %h exp 12347", out_rd1); end
    n_tests++; if (out_rd2 !== 20'h12348) begin n_fail++; $display("FAIL load_rd2: got %h exp 12348", out_rd2); end
    n_tests++; if (out_sext !== 20'h12349) begin n_fail++; $display("FAIL load_sext: got %h exp 12349", out_sext); end
    n_tests++; if (out_instr !== 20'h1234A) begin n_fail++; $display("FAIL load_instr: got %h exp 1234a", out_instr); end
    n_tests++; if (out_dst !== 3'd4) begin n_fail++; $display("FAIL load_dst: got %0d exp 4", out_dst); end
    // in_valid=0 loads a bubble: control cleared, datapath held
    present(1'b0, 10'h3FF, 3'd7, 20'hFFFFF, 3'd0, 3'd0, 3'd0);
    tick();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL idle_valid: got %b exp 0", out_valid); end
    n_tests++; if (out_ctrl !== 10'h0) begin n_fail++; $display("FAIL idle_ctrl: got %h exp 000", out_ctrl); end
    n_tests++; if (out_aluop !== 3'd0) begin n_fail++; $display("FAIL idle_aluop: got %0d exp 0", out_aluop); end
    n_tests++; if (out_rd1 !== 20'h12347) begin n_fail++; $display("FAIL idle_rd1_hold: got %h exp 12347", out_rd1); end
    n_tests++; if (hazard_cnt !== 16'd0) begin n_fail++; $display("FAIL idle_cnt: got %0d exp 0", hazard_cnt); end
  endtask

  task automatic test_load_use();
    present(1'b1, 10'h00A, 3'd1, 20'h00100, 3'd1, 3'd2, 3'd3);   // lw r3
    tick();
    n_tests++; if (out_ctrl !== 10'h00A) begin n_fail++; $display("FAIL lu_lw_ctrl: got %h exp 00a", out_ctrl); end
    present(1'b1, 10'h003, 3'd2, 20'h00200, 3'd3, 3'd5, 3'd6);   // reads r3
    #1;
    n_tests++; if (hazard !== 1'b1) begin n_fail++; $display("FAIL lu_hazard: got %b exp 1", hazard); end
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL lu_ready: got %b exp 0", in_ready); end
    tick();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL lu_bubble_valid: got %b exp 0", out_valid); end
    n_tests++; if (out_ctrl !== 10'h0) begin n_fail++; $display("FAIL lu_bubble_ctrl: got %h exp 000", out_ctrl); end
    n_tests++; if (out_rd1 !== 20'h00102) begin n_fail++; $display("FAIL lu_bubble_rd1: got %h exp 00102", out_rd1); end
    n_tests++; if (hazard_cnt !== 16'd1) begin n_fail++; $display("FAIL lu_cnt: got %0d exp 1", hazard_cnt); end
    n_tests++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL lu_hazard_clear: got %b exp 0", hazard); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL lu_ready_back: got %b exp 1", in_ready); end
    tick();
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL lu_pass_valid: got %b exp 1", out_valid); end
    n_tests++; if (out_ctrl !== 10'h003) begin n_fail++; $display("FAIL lu_pass_ctrl: got %h exp 003", out_ctrl); end
    n_tests++; if (out_rd1 !== 20'h00202) begin n_fail++; $display("FAIL lu_pass_rd1: got %h exp 00202", out_rd1); end
    n_tests++; if (out_dst !== 3'd6) begin n_fail++; $display("FAIL lu_pass_dst: got %0d exp 6", out_dst); end
    n_tests++; if (hazard_cnt !== 16'd1) begin n_fail++; $display("FAIL lu_pass_cnt: got %0d exp 1", hazard_cnt); end
    // Dependency through rt
    present(1'b1, 10'h00A, 3'd1, 20'h00300, 3'd1, 3'd2, 3'd5);   // lw r5
    tick();
    present(1'b1, 10'h003, 3'd2, 20'h00400, 3'd4, 3'd5, 3'd7);
    #1;
    n_tests++; if (hazard !== 1'b1) begin n_fail++; $display("FAIL lu_rt_hazard: got %b exp 1", hazard); end
    tick();
    n_tests++; if (hazard_cnt !== 16'd2) begin n_fail++; $display("FAIL lu_rt_cnt: got %0d exp 2", hazard_cnt); end
    tick();
    n_tests++; if (out_rd1 !== 20'h00402) begin n_fail++; $display("FAIL lu_rt_pass: got %h exp 00402", out_rd1); end
  endtask

  task automatic test_r0();
    present(1'b1, 10'h00A, 3'd1, 20'h00500, 3'd1, 3'd2, 3'd0);   // lw r0
    tick();
    present(1'b1, 10'h003, 3'd2, 20'h00600, 3'd0, 3'd0, 3'd1);
    #1;
    n_tests++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL r0_hazard: got %b exp 0", hazard); end
    tick();
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL r0_valid: got %b exp 1", out_valid); end
    n_tests++; if (out_rd1 !== 20'h00602) begin n_fail++; $display("FAIL r0_rd1: got %h exp 00602", out_rd1); end
    n_tests++; if (hazard_cnt !== 16'd2) begin n_fail++; $display("FAIL r0_cnt: got %0d exp 2", hazard_cnt); end
  endtask

  task automatic test_flush_stall();
    present(1'b1, 10'h00A, 3'd1, 20'h00700, 3'd1, 3'd2, 3'd3);
    tick();
    present(1'b1, 10'h003, 3'd2, 20'h00800, 3'd3, 3'd3, 3'd1);
    flush = 1'b1; ex_stall = 1'b1;
    #1;
    n_tests++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL fl_hazard: got %b exp 0", hazard); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL fl_ready: got %b exp 1", in_ready); end
    tick();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fl_valid: got %b exp 0", out_valid); end
    n_tests++; if (out_ctrl !== 10'h0) begin n_fail++; $display("FAIL fl_ctrl: got %h exp 000", out_ctrl); end
    n_tests++; if (out_aluop !== 3'd0) begin n_fail++; $display("FAIL fl_aluop: got %0d exp 0", out_aluop); end
    n_tests++; if (hazard_cnt !== 16'd2) begin n_fail++; $display("FAIL fl_cnt: got %0d exp 2", hazard_cnt); end
    flush = 1'b0; ex_stall = 1'b0;
  endtask

  task automatic test_stall();
    present(1'b1, 10'h00A, 3'd4, 20'h00900, 3'd1, 3'd2, 3'd3);
    tick();
    present(1'b1, 10'h003, 3'd2, 20'h00A00, 3'd3, 3'd1, 3'd1);
    ex_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL st_ready[%0d]: got %b exp 0", i, in_ready); end
      tick();
      n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL st_valid[%0d]: got %b exp 1", i, out_valid); end
      n_tests++; if (out_ctrl !== 10'h00A) begin n_fail++; $display("FAIL st_ctrl[%0d]: got %h exp 00a", i, out_ctrl); end
      n_tests++; if (out_aluop !== 3'd4) begin n_fail++; $display("FAIL st_aluop[%0d]: got %0d exp 4", i, out_aluop); end
      n_tests++; if (out_rd1 !== 20'h00902) begin n_fail++; $display("FAIL st_rd1[%0d]: got %h exp 00902", i, out_rd1); end
      n_tests++; if (hazard_cnt !== 16'd2) begin n_fail++; $display("FAIL st_cnt[%0d]: got %0d exp 2", i, hazard_cnt); end
    end
    ex_stall = 1'b0;
    tick();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL st_bubble: got %b exp 0", out_valid); end
    n_tests++; if (hazard_cnt !== 16'd3) begin n_fail++; $display("FAIL st_bubble_cnt: got %0d exp 3", hazard_cnt); end
    tick();
    n_tests++; if (out_rd1 !== 20'h00A02) begin n_fail++; $display("FAIL st_pass_rd1: got %h exp 00a02", out_rd1); end
  endtask

  task automatic test_reset_midstream();
    present(1'b0, 10'h0, 3'd0, 20'h0, 3'd0, 3'd0, 3'd0);
    #2;
    rst = 1'b1;
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mrst_valid: got %b exp 0", out_valid); end
    n_tests++; if (out_ctrl !== 10'h0) begin n_fail++; $display("FAIL mrst_ctrl: got %h exp 000", out_ctrl); end
    n_tests++; if (out_rd1 !== 20'h0) begin n_fail++; $display("FAIL mrst_rd1: got %h exp 0", out_rd1); end
    n_tests++; if (out_instr !== 20'h0) begin n_fail++; $display("FAIL mrst_instr: got %h exp 0", out_instr); end
    n_tests++; if (out_dst !== 3'd0) begin n_fail++; $display("FAIL mrst_dst: got %0d exp 0", out_dst); end
    n_tests++; if (hazard_cnt !== 16'd0) begin n_fail++; $display("FAIL mrst_cnt: got %0d exp 0", hazard_cnt); end
    n_tests++; if (s_hazard_cnt !== 2'd0) begin n_fail++; $display("FAIL mrst_scnt: got %0d exp 0", s_hazard_cnt); end
    #1;
    rst = 1'b0;
    tick();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mrst_empty: got %b exp 0", out_valid); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 4; i++) begin
      present(1'b1, 10'h00A, 3'd1, 20'h01000, 3'd1, 3'd2, 3'd3);
      tick();
      present(1'b1, 10'h003, 3'd2, 20'h02000, 3'd3, 3'd1, 3'd1);
      tick();
    end
    n_tests++; if (s_hazard_cnt !== 2'd3) begin n_fail++; $display("FAIL sat_scnt: got %0d exp 3", s_hazard_cnt); end
    n_tests++; if (hazard_cnt !== 16'd4) begin n_fail++; $display("FAIL sat_cnt: got %0d exp 4", hazard_cnt); end
    n_tests++; if (s_out_valid !== 1'b0) begin n_fail++; $display("FAIL sat_svalid: got %b exp 0", s_out_valid); end
    present(1'b1, 10'h00A, 3'd1, 20'h03000, 3'd1, 3'd2, 3'd3);
    tick();
    present(1'b1, 10'h003, 3'd2, 20'h04000, 3'd3, 3'd1, 3'd1);
    cnt_clr = 1'b1;
    #1;
    n_tests++; if (s_hazard !== 1'b1) begin n_fail++; $display("FAIL clr_hazard: got %b exp 1", s_hazard); end
    tick();
    n_tests++; if (s_hazard_cnt !== 2'd0) begin n_fail++; $display("FAIL clr_scnt: got %0d exp 0", s_hazard_cnt); end
    n_tests++; if (hazard_cnt !== 16'd0) begin n_fail++; $display("FAIL clr_cnt: got %0d exp 0", hazard_cnt); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL clr_bubble: got %b exp 0", out_valid); end
    cnt_clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load();
    test_load_use();
    test_r0();
    test_flush_stall();
    test_stall();
    test_reset_midstream();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_pipe_reg.md
ID_EX_PIPE_REG -- requirements
Module: id_ex_pipe_reg

Interface
REQ-001 SHALL take parameter DATA_W, 20, width of all datapath fields (shift/jump, PC+1, read data 1/2, sign-extended immediate, instruction).
REQ-002 SHALL take parameter CTRL_W, 10, control bundle width in bit order regdest, regwrite, alusrc, memread, memwrite, memtoreg, j, branch, jmem, stw (bit 0 = regdest).
REQ-003 SHALL take parameter ALUOP_W, 3, ALU operation code width.
REQ-004 SHALL take parameter REG_AW, 3, register-address width.
REQ-005 SHALL take parameter CNT_W, 16, hazard-counter width.
REQ-006 clk  in  1  single clock, all state on rising edge.
REQ-007 rst  in  1  reset, asynchronous, active-high.
REQ-008 in_valid  in  1  ID holds a real instruction.
REQ-009 in_ready  out  1  stage accepts the ID instruction this cycle.
REQ-010 in_ctrl  in  CTRL_W  control bundle; in_aluop  in  ALUOP_W.
REQ-011 in_shift_jump, in_pc_inc, in_rd1, in_rd2, in_sext, in_instr  in  DATA_W each  datapath fields.
REQ-012 in_rs, in_rt, in_dst  in  REG_AW each  source registers and destination register.
REQ-013 flush  in  1  squash stage contents (taken branch/jump).
REQ-014 ex_stall  in  1  downstream stall; hold stage.
REQ-015 cnt_clr  in  1  synchronous clear of hazard counter.
REQ-016 out_valid  out  1; out_ctrl, out_aluop, out_* datapath, out_dst: registered copies of each in_* field.
REQ-017 hazard  out  1  load-use hazard detected (combinational).
REQ-018 hazard_cnt  out  CNT_W  bubbles inserted due to hazard.

Function
REQ-019 hazard SHALL be 1 iff out_valid & out_ctrl[3] (memread) & out_dst != 0 & in_valid & (out_dst == in_rs | out_dst == in_rt) & !flush.
REQ-020 in_ready SHALL be !ex_stall & !hazard, or 1 whenever flush = 1.
REQ-021 Per-edge priority SHALL be rst > flush > ex_stall > hazard > load.
REQ-022 flush: out_valid <= 0, out_ctrl <= 0, out_aluop <= 0 even if ex_stall = 1; ID instruction discarded.
REQ-023 ex_stall (no flush): all outputs hold.
REQ-024 hazard (no flush/stall): bubble loaded (out_valid <= 0, out_ctrl <= 0, out_aluop <= 0); datapath outputs hold; ID instruction not consumed, re-presented next cycle.
REQ-025 load: in_valid = 1 -> every out_* <= in_*, out_valid <= 1; in_valid = 0 -> bubble as REQ-024.
REQ-026 Latency SHALL be exactly one cycle from accepted input to output.
REQ-027 A bubble's out_ctrl SHALL be all-zero so no write, memory access or branch occurs downstream.
REQ-028 hazard_cnt SHALL increment by 1 on each edge where REQ-024 applies, saturate at 2^CNT_W-1, and go to 0 on cnt_clr (cnt_clr beats increment).
REQ-029 A single load-use hazard SHALL produce exactly one bubble: after the bubble, out_valid = 0 so hazard deasserts.

Reset
REQ-030 rst = 1 SHALL immediately force every output register (out_valid, out_ctrl, out_aluop, datapath, out_dst, hazard_cnt) to 0, independent of clk.
REQ-031 Release of rst mid-stream SHALL leave the stage empty; the first edge after release follows REQ-021.

Structure
REQ-032 Control-bit index constants (CTRL_REGDEST=0 .. CTRL_STW=9, CTRL_MEMREAD=3) and default widths SHALL live in shared package mips20_pkg.
REQ-033 Hazard detection SHALL be a sub-module load_use_detect (pure combinational compare); register and counter logic in id_ex_pipe_reg.

Verification
REQ-034 Reset: rst pulse mid-cycle with out_valid=1 -> all outputs 0 before next edge, hazard_cnt=0.
REQ-035 Load-use: lw to r3 accepted, next in_rs=3 -> hazard=1, in_ready=0, one bubble, then instruction passes; hazard_cnt=1.
REQ-036 No hazard on r0: load with out_dst=0, in_rs=0 -> hazard=0, no bubble.
REQ-037 flush+ex_stall same edge with valid load in stage -> out_valid=0, out_ctrl=0, in_ready=1.
REQ-038 ex_stall 3 cycles -> outputs unchanged 3 cycles, in_ready=0, hazard_cnt unchanged.
REQ-039 CNT_W=2: four hazards -> hazard_cnt stops at 3; cnt_clr with concurrent hazard -> 0.
